csr_dec_hls_deadlock_reporter: RTL
==================================

# csr_dec_hls_deadlock_reporter

Downstream consumer of the per-instance HLS deadlock monitor `block` outputs in the csr_dec design. It qualifies raw block indications by persistence, so a stall counts as a deadlock only after THRESH consecutive blocked cycles. On qualification it latches a sticky deadlock flag, the bitmap of monitors that were blocking, and a cycle timestamp. It then presents exactly one report record on a valid/ready interface to the debug/CSR readout logic.

## Interface
- NUM_MON, 4, number of monitor `block` inputs (1..32)
- THRESH, 1024, consecutive blocked cycles required to declare deadlock (>= 1)
- CNT_W, 32, timestamp width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- block_sigs  in  NUM_MON  one bit per monitor `block` output, sampled every cycle
- clear  in  1  software clear of sticky state (level, sampled each cycle)
- rpt_valid  out  1  report record valid
- rpt_ready  in  1  consumer accepts record
- rpt_mask  out  NUM_MON  block_sigs value sampled in the qualifying cycle
- rpt_time  out  CNT_W  cycle-counter value in the qualifying cycle
- deadlock  out  1  sticky deadlock flag

## Operation
- Free-running cycle counter `cyc`:
  - 0 in the first cycle after reset deasserts, +1 every cycle.
  - Wraps modulo 2^CNT_W.
- Run counter `run`:
  - Counts consecutive cycles with |block_sigs = 1.
  - Width clog2(THRESH+1).
  - Cleared to 0 in any cycle with |block_sigs = 0.
  - Saturates at THRESH.
- The set of blocking bits may change during a run (0001 -> 0100 with no all-zero cycle); the run continues.
- FSM states: WATCH (reset state), REPORT, HALT.
- WATCH:
  - The qualifying cycle is the cycle where |block_sigs = 1 and run = THRESH-1.
  - On the qualifying cycle, capture rpt_mask = block_sigs and rpt_time = cyc, set deadlock = 1, go to REPORT.
  - clear = 1 in WATCH forces run to 0 that cycle and overrides blocking.
- REPORT:
  - rpt_valid = 1.
  - rpt_mask and rpt_time are held stable until the handshake (rpt_valid & rpt_ready).
  - On the handshake: go to HALT, rpt_valid = 0.
  - clear is ignored in REPORT; the record is never dropped.
- HALT:
  - deadlock stays 1, block_sigs are ignored, run is held at 0.
  - clear = 1: deadlock = 0, go to WATCH. Counting restarts from the next cycle.
  - rpt_mask and rpt_time keep their captured values until the next capture or reset.
- Only one report is issued per deadlock episode.

## Timing
- Reset values: rpt_valid = 0, rpt_mask = 0, rpt_time = 0, deadlock = 0, run = 0, cyc = 0, state = WATCH.
- Reset asserted in any state, including mid-REPORT, takes effect at the next edge. Any pending record is discarded.
- Latency: rpt_valid and deadlock rise on the cycle after the qualifying cycle.
- With THRESH = 1, a single blocked cycle qualifies.
- rpt_valid falls on the cycle after the handshake cycle.
- rpt_ready may be held high permanently. Minimum REPORT residency is 1 cycle.
- Clear in HALT: deadlock = 0 on the next cycle. The earliest possible re-qualification is THRESH cycles after WATCH is re-entered.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- CSR_DEC_DEADLOCK_TIMESTAMP_EN defined:
  - The cyc counter is implemented.
  - rpt_time is captured as described above.
- Not defined:
  - The cyc counter is removed.
  - rpt_time is tied to 0.
  - All other behaviour is identical.

## Test plan
- THRESH=8, block_sigs=0001 for 7 cycles, then 0000: rpt_valid and deadlock stay 0, run returns to 0.
- THRESH=8, macro on, block_sigs=0010 for cycles cyc=10..17, rpt_ready=1:
  - Cycle 18: rpt_valid=1, rpt_mask=0010, rpt_time=17, deadlock=1.
  - Cycle 19: rpt_valid=0.
- Run with block_sigs 0001 (cycles 0-3) then 0100 (cycles 4-7), THRESH=8: the report issues with rpt_mask=0100, so the run is continuous.
- Handshake backpressure: rpt_ready=0 for 5 cycles in REPORT, with clear=1 pulsed.
  - rpt_valid, rpt_mask and rpt_time stay stable; clear has no effect.
  - rpt_ready=1: rpt_valid drops next cycle, deadlock stays 1.
  - Block continues in HALT: no second report.
- In HALT, assert clear for 1 cycle: deadlock=0 next cycle; a fresh 8-cycle run yields a second report.
- Reset asserted in REPORT with rpt_ready=0: next cycle all outputs are 0 and state is WATCH. Macro undefined: rpt_time stays 0 in every report.

Source files
------------

// File: rtl/csr_dec_hls_deadlock_reporter.sv
// -----------------------------------------------------------------------------
// csr_dec_hls_deadlock_reporter
//
// Consumes the per-instance HLS deadlock monitor `block` outputs and decides
// when a stall is a real deadlock. A stall qualifies only after THRESH
// consecutive cycles with at least one monitor blocking. The set of blocking
// monitors may change during a run without breaking it. On qualification the
// block latches a sticky deadlock flag, the monitor bitmap and a cycle
// timestamp. It then offers exactly one report record on a valid/ready
// interface. After the handshake it halts until software clears it.
//
// Parameters
//   NUM_MON  number of monitor `block` inputs (1..32)
//   THRESH   consecutive blocked cycles required to declare deadlock (>= 1)
//   CNT_W    timestamp width
//
// Ports
//   clock       in   clock
//   reset       in   synchronous, active-high reset
//   block_sigs  in   [NUM_MON] one bit per monitor, sampled every cycle
//   clear       in   software clear of sticky state (level)
//   rpt_valid   out  report record valid
//   rpt_ready   in   consumer accepts the record
//   rpt_mask    out  [NUM_MON] block_sigs captured in the qualifying cycle
//   rpt_time    out  [CNT_W] cycle counter captured in the qualifying cycle
//   deadlock    out  sticky deadlock flag
//
// Configuration
//   CSR_DEC_DEADLOCK_TIMESTAMP_EN  when defined, the free-running cycle
//   counter is built and rpt_time carries the capture time. When it is not
//   defined, the counter is removed and rpt_time is tied to 0.
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module csr_dec_hls_deadlock_reporter #(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [NUM_MON-1:0] rpt_mask,
    output logic [CNT_W-1:0]   rpt_time,
    output logic               deadlock
);

    // The run counter must hold the value THRESH.
    localparam int RUN_W = $clog2(THRESH + 1);

    // The last run value before qualification. The cycle that sees this value
    // while still blocked is the THRESH-th consecutive blocked cycle.
    localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(THRESH - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(THRESH);

    typedef enum logic [1:0] {
        WATCH  = 2'd0,  // counting blocked cycles
        REPORT = 2'd1,  // record offered, waiting for the consumer
        HALT   = 2'd2   // record delivered, waiting for software clear
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_next;
    logic               deadlock_next;
    logic               capture;
    logic               any_block;

    assign any_block = |block_sigs;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a combinational output unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        run_next      = run;
        deadlock_next = deadlock;
        capture       = 1'b0;

        unique case (state)
            WATCH: begin
                if (clear || !any_block) begin
                    // A software clear overrides any blocking seen this cycle.
                    run_next = '0;
                end else if (run == RUN_QUAL) begin
                    // Qualifying cycle. The run is consumed by this report.
                    // It can only start again once the episode is cleared.
                    capture       = 1'b1;
                    deadlock_next = 1'b1;
                    run_next      = '0;
                    state_next    = REPORT;
                end else if (run != RUN_MAX) begin
                    run_next = run + RUN_W'(1);
                end
            end

            REPORT: begin
                // clear is ignored here. The record is never dropped.
                run_next = '0;
                if (rpt_ready) begin
                    state_next = HALT;
                end
            end

            HALT: begin
                // block_sigs are ignored. One report per episode.
                run_next = '0;
                if (clear) begin
                    deadlock_next = 1'b0;
                    state_next    = WATCH;
                end
            end

            default: begin
                run_next      = '0;
                deadlock_next = 1'b0;
                state_next    = WATCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, run counter and flags
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge values, whatever the order of the blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WATCH;
            run       <= '0;
            deadlock  <= 1'b0;
            rpt_valid <= 1'b0;
        end else begin
            state     <= state_next;
            run       <= run_next;
            deadlock  <= deadlock_next;
            // Registered copy of "in REPORT". rpt_valid rises the cycle after
            // qualification and falls the cycle after the handshake.
            rpt_valid <= (state_next == REPORT);
        end
    end

    // The mask register is reset as well. A reset must discard a pending
    // record, and the readout is defined as 0 until the first capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_mask <= '0;
        end else if (capture) begin
            rpt_mask <= block_sigs;
        end
    end

    // -------------------------------------------------------------------------
    // Optional timestamp
    // -------------------------------------------------------------------------
`ifdef CSR_DEC_DEADLOCK_TIMESTAMP_EN
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] rpt_time_q;

    // Reads 0 in the first cycle after reset is released. It wraps naturally
    // modulo 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_time_q <= '0;
        end else if (capture) begin
            rpt_time_q <= cyc;
        end
    end

    assign rpt_time = rpt_time_q;
`else
    assign rpt_time = '0;
`endif

endmodule
